// File: rtl/imem_bus_monitor_pkg.sv
// Shared types and helpers for the instruction-memory bus monitor.
package imem_bus_monitor_pkg;

  // Protocol tracker states: no request, request waiting for ready, protocol broken.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } imem_mon_state_e;

  // Width of one tracked instruction parcel.
  localparam int PARCEL_W = 16;

  // Number of 16-bit parcels carried by one bus word.
  function automatic int parcels_per_word(input int xlen);
    return xlen / PARCEL_W;
  endfunction

endpackage

// File: rtl/imem_bus_monitor_if.sv
// Native valid/ready memory bus of the core, as seen by the monitor.
interface imem_bus_monitor_if #(
  parameter int XLEN = 32
);
  logic              mem_valid;
  logic              mem_instr;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;

  // Core side: issues requests, receives responses.
  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  // Memory side: accepts requests, returns responses.
  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wstrb,
    output mem_ready, mem_rdata
  );

  // Passive observer: sees every bus signal, drives none.
  modport monitor (
    input mem_valid, mem_instr, mem_ready, mem_addr, mem_wstrb, mem_rdata
  );
endinterface

// File: rtl/imem_parcel_match.sv
// Checks one tracked (address, parcel) pair against a completing read word.
module imem_parcel_match
  import imem_bus_monitor_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                check_en,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     rdata,
  input  logic [XLEN-1:0]     chk_addr,
  input  logic [PARCEL_W-1:0] chk_data,
  output logic                match_ok
);

  localparam int NPARCEL = parcels_per_word(XLEN);

  // Any parcel of the word landing on the tracked address must carry the tracked value.
  always_comb begin
    match_ok = 1'b1;
    for (int k = 0; k < NPARCEL; k++) begin
      if (check_en && ((addr + XLEN'(2 * k)) == chk_addr) &&
          (rdata[k*PARCEL_W +: PARCEL_W] != chk_data)) begin
        match_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/imem_bus_monitor.sv
// Bus monitor: read-data consistency against tracked imem parcels, protocol
// stability, bounded-wait and fetch statistics.
// Optional write guard enabled by defining IMEM_BUS_MONITOR_WGUARD_EN.
module imem_bus_monitor
  import imem_bus_monitor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NCHAN    = 2,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16,
  localparam int STALL_W = $clog2(MAX_WAIT + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  imem_bus_monitor_if.monitor       bus,
  input  logic [NCHAN-1:0]          chk_valid,
  input  logic [NCHAN*XLEN-1:0]     chk_addr,
  input  logic [NCHAN*PARCEL_W-1:0] chk_data,
  output logic                      rdata_ok,
  output logic                      fetch_done,
  output logic [STALL_W-1:0]        stall_cnt,
  output logic                      stall_err,
  output logic                      proto_err,
  output logic [CNT_W-1:0]          fetch_count
);

  localparam int NBYTE = XLEN / 8;

  imem_mon_state_e   state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NBYTE-1:0]  wstrb_q, wstrb_d;
  logic              instr_q, instr_d;
  logic              proto_err_q, proto_err_d;
  logic              stall_err_q, stall_err_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
  logic              fetch_done_q, fetch_done_d;

  logic              complete;
  logic              pending;
  logic              is_read;
  logic              check_base;
  logic [NCHAN-1:0]  match_ok;
  logic              wr_hit;
  logic              guard_trip;

  assign complete   = bus.mem_valid && bus.mem_ready;
  assign pending    = bus.mem_valid && !bus.mem_ready;
  assign is_read    = (bus.mem_wstrb == '0);
  assign check_base = resetn && enable && complete && is_read;

  for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
    imem_parcel_match #(
      .XLEN(XLEN)
    ) u_match (
      .check_en (check_base && chk_valid[ch]),
      .addr     (bus.mem_addr),
      .rdata    (bus.mem_rdata),
      .chk_addr (chk_addr[ch*XLEN +: XLEN]),
      .chk_data (chk_data[ch*PARCEL_W +: PARCEL_W]),
      .match_ok (match_ok[ch])
    );
  end

  assign rdata_ok = &match_ok;

`ifdef IMEM_BUS_MONITOR_WGUARD_EN
  // Flag a write whose enabled byte lanes touch either byte of an active tracked parcel.
  always_comb begin
    wr_hit = 1'b0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      for (int j = 0; j < NBYTE; j++) begin
        if (chk_valid[ch] && bus.mem_wstrb[j] &&
            (((bus.mem_addr + XLEN'(j)) == chk_addr[ch*XLEN +: XLEN]) ||
             ((bus.mem_addr + XLEN'(j)) == (chk_addr[ch*XLEN +: XLEN] + XLEN'(1))))) begin
          wr_hit = 1'b1;
        end
      end
    end
  end
`else
  assign wr_hit = 1'b0;
`endif

  assign guard_trip = complete && !is_read && wr_hit;

  // Protocol tracker: a pending request must stay asserted and stable until ready.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    instr_d     = instr_q;
    proto_err_d = proto_err_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (pending) begin
            state_d = BUSY;
            addr_d  = bus.mem_addr;
            wstrb_d = bus.mem_wstrb;
            instr_d = bus.mem_instr;
          end
        end
        BUSY: begin
          if (!bus.mem_valid || (bus.mem_addr != addr_q) ||
              (bus.mem_wstrb != wstrb_q) || (bus.mem_instr != instr_q)) begin
            state_d     = ERR;
            proto_err_d = 1'b1;
          end else if (bus.mem_ready) begin
            state_d = IDLE;
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      if (guard_trip) begin
        state_d     = ERR;
        proto_err_d = 1'b1;
      end
    end
  end

  // Wait counting and fetch statistics; the fetch pulse only reports enabled completions.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    stall_err_d   = stall_err_q;
    fetch_count_d = fetch_count_q;
    fetch_done_d  = 1'b0;
    if (enable) begin
      if (pending) begin
        if (stall_cnt_q == STALL_W'(MAX_WAIT)) begin
          stall_err_d = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end else begin
        stall_cnt_d = '0;
      end
      if (complete && bus.mem_instr && is_read) begin
        fetch_done_d = 1'b1;
        if (fetch_count_q != '1) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wstrb_q       <= '0;
      instr_q       <= 1'b0;
      proto_err_q   <= 1'b0;
      stall_err_q   <= 1'b0;
      stall_cnt_q   <= '0;
      fetch_count_q <= '0;
      fetch_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wstrb_q       <= wstrb_d;
      instr_q       <= instr_d;
      proto_err_q   <= proto_err_d;
      stall_err_q   <= stall_err_d;
      stall_cnt_q   <= stall_cnt_d;
      fetch_count_q <= fetch_count_d;
      fetch_done_q  <= fetch_done_d;
    end
  end

  assign fetch_done  = fetch_done_q;
  assign stall_cnt   = stall_cnt_q;
  assign stall_err   = stall_err_q;
  assign proto_err   = proto_err_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_bus_monitor.sv
// Self-checking bench for imem_bus_monitor: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_imem_bus_monitor;

  localparam int XLEN     = 32;
  localparam int NCHAN    = 2;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int STALL_W  = $clog2(MAX_WAIT + 1);
  localparam int NBYTE    = XLEN / 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk;
  logic resetn;
  logic enable;
  logic [NCHAN-1:0]      chk_valid;
  logic [NCHAN*XLEN-1:0] chk_addr;
  logic [NCHAN*16-1:0]   chk_data;
  logic                  rdata_ok;
  logic                  fetch_done;
  logic [STALL_W-1:0]    stall_cnt;
  logic                  stall_err;
  logic                  proto_err;
  logic [CNT_W-1:0]      fetch_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  imem_bus_monitor_if #(.XLEN(XLEN)) bus_if ();

  imem_bus_monitor #(
    .XLEN(XLEN), .NCHAN(NCHAN), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .bus(bus_if),
    .chk_valid(chk_valid), .chk_addr(chk_addr), .chk_data(chk_data),
    .rdata_ok(rdata_ok), .fetch_done(fetch_done), .stall_cnt(stall_cnt),
    .stall_err(stall_err), .proto_err(proto_err), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, expressed as transaction facts rather than registers
  bit              m_pending;
  logic [XLEN-1:0] m_addr;
  logic [NBYTE-1:0] m_wstrb;
  bit              m_instr;
  bit              m_err;
  int              m_run;
  bit              m_stall_err;
  int              m_fetches;
  bit              m_fetch_done;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit ins, input bit rdy,
                               input logic [XLEN-1:0] a, input logic [NBYTE-1:0] ws,
                               input logic [XLEN-1:0] rd);
    bus_if.mem_valid = v;
    bus_if.mem_instr = ins;
    bus_if.mem_ready = rdy;
    bus_if.mem_addr  = a;
    bus_if.mem_wstrb = ws;
    bus_if.mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setChan(input int c, input bit v, input logic [XLEN-1:0] a, input logic [15:0] d);
    chk_valid[c]            = v;
    chk_addr[c*XLEN +: XLEN] = a;
    chk_data[c*16 +: 16]    = d;
  endtask

  // Read consistency: locate the tracked parcel inside the word by byte offset
  function automatic bit model_rdata_ok();
    logic [XLEN-1:0] off;
    int k;
    if (!resetn || !enable || !(bus_if.mem_valid && bus_if.mem_ready) || bus_if.mem_wstrb != 0)
      return 1'b1;
    for (int c = 0; c < NCHAN; c++) begin
      if (chk_valid[c]) begin
        off = chk_addr[c*XLEN +: XLEN] - bus_if.mem_addr;
        if (off[0] == 1'b0 && off < NBYTE) begin
          k = int'(off) / 2;
          if (bus_if.mem_rdata[k*16 +: 16] != chk_data[c*16 +: 16]) return 1'b0;
        end
      end
    end
    return 1'b1;
  endfunction

`ifdef IMEM_BUS_MONITOR_WGUARD_EN
  function automatic bit model_write_hit();
    logic [XLEN-1:0] d;
    for (int c = 0; c < NCHAN; c++)
      for (int j = 0; j < NBYTE; j++)
        if (chk_valid[c] && bus_if.mem_wstrb[j]) begin
          d = bus_if.mem_addr + XLEN'(j) - chk_addr[c*XLEN +: XLEN];
          if (d == 0 || d == 1) return 1'b1;
        end
    return 1'b0;
  endfunction
`endif

  // Model advances on each clock edge from the inputs held over the previous cycle
  always @(posedge clk) begin
    if (!resetn) begin
      m_pending = 0; m_addr = '0; m_wstrb = '0; m_instr = 0; m_err = 0;
      m_run = 0; m_stall_err = 0; m_fetches = 0; m_fetch_done = 0;
    end else begin
      m_fetch_done = 0;
      if (enable) begin
        if (bus_if.mem_valid && bus_if.mem_ready && bus_if.mem_instr && bus_if.mem_wstrb == 0) begin
          m_fetch_done = 1;
          m_fetches++;
        end
        if (bus_if.mem_valid && !bus_if.mem_ready) begin
          m_run++;
          if (m_run > MAX_WAIT) m_stall_err = 1;
        end else begin
          m_run = 0;
        end
        if (!m_err) begin
          if (m_pending) begin
            if (!bus_if.mem_valid || bus_if.mem_addr != m_addr ||
                bus_if.mem_wstrb != m_wstrb || bus_if.mem_instr != m_instr)
              m_err = 1;
            else if (bus_if.mem_ready)
              m_pending = 0;
          end else if (bus_if.mem_valid && !bus_if.mem_ready) begin
            m_pending = 1;
            m_addr    = bus_if.mem_addr;
            m_wstrb   = bus_if.mem_wstrb;
            m_instr   = bus_if.mem_instr;
          end
        end
`ifdef IMEM_BUS_MONITOR_WGUARD_EN
        if (bus_if.mem_valid && bus_if.mem_ready && bus_if.mem_wstrb != 0 && model_write_hit())
          m_err = 1;
`endif
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_rdata_ok", rdata_ok, model_rdata_ok());
      checkOutput("cyc_fetch_done", fetch_done, m_fetch_done);
      checkOutput("cyc_stall_cnt", stall_cnt, (m_run > MAX_WAIT) ? MAX_WAIT : m_run);
      checkOutput("cyc_stall_err", stall_err, m_stall_err);
      checkOutput("cyc_proto_err", proto_err, m_err);
      checkOutput("cyc_fetch_count", fetch_count, (m_fetches > CNT_MAX) ? CNT_MAX : m_fetches);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  bit prev_pending;

  initial begin
    resetn = 1'b0;
    enable = 1'b1;
    chk_valid = '0;
    chk_addr  = '0;
    chk_data  = '0;
    applyStimulus(0, 0, 0, '0, '0, '0);
    step();
    cmp_en = 1;

    // Reset holds rdata_ok high even for a mismatching fetch
    setChan(0, 1, 32'h100, 16'hFFFF);
    applyStimulus(1, 1, 1, 32'h100, 4'h0, 32'h12345678);
    @(negedge clk);
    checkOutput("reset_rdata_ok", rdata_ok, 1);
    step();
    checkOutput("reset_fetch_count", fetch_count, 0);
    checkOutput("reset_fetch_done", fetch_done, 0);
    checkOutput("reset_proto_err", proto_err, 0);
    resetn = 1'b1;

    // Zero-wait fetch matching the upper parcel
    setChan(0, 1, 32'h102, 16'h1234);
    @(negedge clk);
    checkOutput("t1_rdata_ok", rdata_ok, 1);
    step();
    checkOutput("t1_fetch_done", fetch_done, 1);
    checkOutput("t1_fetch_count", fetch_count, 1);

    // Same fetch against a mismatching lower parcel: transient flag only
    setChan(0, 1, 32'h100, 16'hFFFF);
    @(negedge clk);
    checkOutput("t2_rdata_ok", rdata_ok, 0);
    step();
    checkOutput("t2_fetch_count", fetch_count, 2);
    checkOutput("t2_proto_err", proto_err, 0);
    checkOutput("t2_stall_err", stall_err, 0);
    applyStimulus(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("t2_idle_rdata_ok", rdata_ok, 1);
    step();

    // Bounded wait: five pending cycles with MAX_WAIT=4
    applyStimulus(1, 0, 0, 32'h300, 4'h0, '0);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 4) begin
        checkOutput("t3_stall_cnt4", stall_cnt, 4);
        checkOutput("t3_stall_err4", stall_err, 0);
      end
    end
    checkOutput("t3_stall_cnt5", stall_cnt, 4);
    checkOutput("t3_stall_err5", stall_err, 1);
    applyStimulus(1, 0, 1, 32'h300, 4'h0, '0);
    step();
    checkOutput("t3_done_stall_cnt", stall_cnt, 0);
    checkOutput("t3_done_stall_err", stall_err, 1);
    checkOutput("t3_done_proto_err", proto_err, 0);
    applyStimulus(0, 0, 0, '0, '0, '0);
    step();

    // Disabled monitor ignores a mismatching fetch
    enable = 1'b0;
    applyStimulus(1, 1, 1, 32'h100, 4'h0, 32'h12345678);
    @(negedge clk);
    checkOutput("t4_rdata_ok", rdata_ok, 1);
    step();
    checkOutput("t4_fetch_count", fetch_count, 2);
    checkOutput("t4_fetch_done", fetch_done, 0);
    enable = 1'b1;
    applyStimulus(0, 0, 0, '0, '0, '0);
    step();

    // Address change while a request is waiting
    applyStimulus(1, 1, 0, 32'h200, 4'h0, '0);
    step();
    applyStimulus(1, 1, 0, 32'h204, 4'h0, '0);
    step();
    checkOutput("t5_proto_err", proto_err, 1);
    applyStimulus(0, 0, 0, '0, '0, '0);
    repeat (3) step();
    checkOutput("t5_proto_sticky", proto_err, 1);

    // Reset in the middle of a waiting request
    applyStimulus(1, 1, 0, 32'h400, 4'h0, '0);
    step();
    step();
    checkOutput("t6_stall_cnt2", stall_cnt, 2);
    resetn = 1'b0;
    step();
    checkOutput("t6_fetch_done", fetch_done, 0);
    checkOutput("t6_stall_cnt", stall_cnt, 0);
    checkOutput("t6_stall_err", stall_err, 0);
    checkOutput("t6_proto_err", proto_err, 0);
    checkOutput("t6_fetch_count", fetch_count, 0);
    resetn = 1'b1;
    applyStimulus(0, 0, 0, '0, '0, '0);
    step();

    // Write into a tracked parcel
    setChan(0, 1, 32'h102, 16'h1234);
    setChan(1, 0, 32'h0, 16'h0);
    applyStimulus(1, 0, 1, 32'h100, 4'b0100, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t7_rdata_ok", rdata_ok, 1);
    step();
`ifdef IMEM_BUS_MONITOR_WGUARD_EN
    checkOutput("t7_proto_err", proto_err, 1);
`else
    checkOutput("t7_proto_err", proto_err, 0);
`endif
    applyStimulus(0, 0, 0, '0, '0, '0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;

    // Randomized traffic, mostly protocol-clean, compared by the every-cycle process
    prev_pending = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [XLEN-1:0] rd;
      resetn = ($urandom_range(0, 149) != 0);
      enable = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < NCHAN; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          setChan(c, $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0) ? 32'(2 * $urandom_range(0, 1))
                                              : 32'h100 + 32'($urandom_range(0, 15)),
                  $urandom_range(0, 1) ? 16'h1234 : 16'hABCD);
        end
      end
      for (int k = 0; k < XLEN / 16; k++)
        rd[k*16 +: 16] = $urandom_range(0, 1) ? 16'h1234 : 16'hABCD;
      if (prev_pending && $urandom_range(0, 99) < 97) begin
        bus_if.mem_ready = ($urandom_range(0, 9) < 4);
        bus_if.mem_rdata = rd;
      end else begin
        applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 9) < 4,
                      ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFE
                                                   : 32'h100 + 32'($urandom_range(0, 15)),
                      ($urandom_range(0, 9) < 7) ? 4'h0 : 4'($urandom_range(1, 15)), rd);
      end
      prev_pending = bus_if.mem_valid && !bus_if.mem_ready;
      step();
    end

    applyStimulus(0, 0, 0, '0, '0, '0);
    resetn = 1'b1;
    enable = 1'b1;
    step();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
